// File: rtl/tx_serializer.sv
// rtl/tx_serializer.sv - one-lane serializer: COM sync burst, then MSB-first payload or IDLE fill
// A byte is loaded every 8th edge; ready_out is register-decoded so upstream sees no loop through valid_in.
module tx_serializer #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter logic [7:0] IDLE       = 8'h7C,
  parameter int         SYNC_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_serial_out,
  output logic       active_out
);

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // sync_cnt value seen on the load edge that sends the final COM
  localparam logic [7:0] SYNC_LAST = 8'(SYNC_COUNT - 1);

  state_t     state;
  state_t     state_next;
  logic [2:0] bit_cnt;
  logic [7:0] sync_cnt;
  logic [7:0] sync_cnt_next;
  logic [7:0] shreg;
  logic [7:0] shreg_next;
  logic [7:0] sel_byte;
  logic       serial_next;
  logic       load_edge;

  assign load_edge = (bit_cnt == 3'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= SYNC;
      bit_cnt         <= 3'd0;
      sync_cnt        <= 8'd0;
      shreg           <= 8'd0;
      data_serial_out <= 1'b0;
    end else begin
      state           <= state_next;
      bit_cnt         <= bit_cnt + 3'd1;
      sync_cnt        <= sync_cnt_next;
      shreg           <= shreg_next;
      data_serial_out <= serial_next;
    end
  end

  always_comb begin
    state_next    = state;
    sync_cnt_next = sync_cnt;
    sel_byte      = IDLE;
    shreg_next    = shreg;
    serial_next   = shreg[3'd7 - bit_cnt];
    case (state)
      SYNC: begin
        sel_byte = COM;
        if (load_edge) begin
          sync_cnt_next = sync_cnt + 8'd1;
          if (sync_cnt == SYNC_LAST) begin
            state_next = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        sel_byte = valid_in ? data_in : IDLE;
      end
      default: begin
        state_next = SYNC;
      end
    endcase
    // The byte's MSB leaves on the same edge it is captured
    if (load_edge) begin
      shreg_next  = sel_byte;
      serial_next = sel_byte[7];
    end
  end

  assign ready_out  = (state == ACTIVE) && load_edge;
  assign active_out = (state == ACTIVE);

endmodule

// File: tb/tb_tx_serializer.sv
// tb/tb_tx_serializer.sv - randomized bench for tx_serializer against an edge-count reference model
module tb_tx_serializer;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;

  logic       clk;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_a, serial_a, active_a;
  logic       ready_b, serial_b, active_b;

  int vectors;
  int miscompares;

  tx_serializer #(.COM(COM), .IDLE(IDLE), .SYNC_COUNT(4)) dut_a (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_a), .data_serial_out(serial_a), .active_out(active_a)
  );

  tx_serializer #(.COM(COM), .IDLE(IDLE), .SYNC_COUNT(1)) dut_b (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_b), .data_serial_out(serial_b), .active_out(active_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: everything derives from k, the number of edges since reset release
  int         k;
  int         sc [2] = '{4, 1};
  logic [7:0] cur [2];
  logic [7:0] exp_q [$];
  logic [7:0] rx_sr;
  bit         rx_locked;
  int         rx_n;
  int         rx_bytes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s k=%0d got=%0h want=%0h", tag, k, got, want);
    end
  endtask

  task automatic rx_reset();
    rx_sr     = 8'd0;
    rx_locked = 1'b0;
    rx_n      = 0;
    exp_q.delete();
  endtask

  task automatic rx_pop();
    logic [7:0] want;
    if (exp_q.size() == 0) begin
      check("rx_queue_empty", 32'd1, 32'd0);
    end else begin
      want = exp_q.pop_front();
      check("rx_byte", {24'd0, rx_sr}, {24'd0, want});
      rx_bytes++;
    end
  endtask

  task automatic step();
    int         bitpos;
    int         j;
    logic [7:0] b;
    logic [1:0] got_s, got_a, got_r;
    logic [1:0] exp_s, exp_a, exp_r;
    @(posedge clk);
    k++;
    bitpos = (k - 1) % 8;
    for (int i = 0; i < 2; i++) begin
      if (bitpos == 0) begin
        j = (k - 1) / 8;
        if (j < sc[i])     b = COM;
        else if (valid_in) b = data_in;
        else               b = IDLE;
        cur[i] = b;
        if (i == 0) exp_q.push_back(b);
      end
      exp_s[i] = cur[i][7 - bitpos];
      exp_a[i] = (k >= 8 * (sc[i] - 1) + 1);
      exp_r[i] = exp_a[i] && (k % 8 == 0);
    end
    @(negedge clk);
    got_s = {serial_b, serial_a};
    got_a = {active_b, active_a};
    got_r = {ready_b, ready_a};
    check("serial_a", {31'd0, got_s[0]}, {31'd0, exp_s[0]});
    check("serial_b", {31'd0, got_s[1]}, {31'd0, exp_s[1]});
    check("active_a", {31'd0, got_a[0]}, {31'd0, exp_a[0]});
    check("active_b", {31'd0, got_a[1]}, {31'd0, exp_a[1]});
    check("ready_a",  {31'd0, got_r[0]}, {31'd0, exp_r[0]});
    check("ready_b",  {31'd0, got_r[1]}, {31'd0, exp_r[1]});
    // Receiver model: hunt for COM, then slice every 8 bits
    rx_sr = {rx_sr[6:0], serial_a};
    if (!rx_locked) begin
      if (rx_sr == COM) begin
        rx_locked = 1'b1;
        rx_n      = 0;
        rx_pop();
      end
    end else begin
      rx_n++;
      if (rx_n == 8) begin
        rx_n = 0;
        rx_pop();
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    #1;
    check("rst_serial_a", {31'd0, serial_a}, 32'd0);
    check("rst_active_a", {31'd0, active_a}, 32'd0);
    check("rst_ready_a",  {31'd0, ready_a},  32'd0);
    check("rst_serial_b", {31'd0, serial_b}, 32'd0);
    check("rst_active_b", {31'd0, active_b}, 32'd0);
    check("rst_ready_b",  {31'd0, ready_b},  32'd0);
    repeat (cycles) @(negedge clk);
    reset = 1'b1;
    k     = 0;
    cur[0] = 8'd0;
    cur[1] = 8'd0;
    rx_reset();
  endtask

  task automatic run_idle(input int n);
    valid_in = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rx_bytes    = 0;
    k           = 0;
    data_in     = 8'd0;
    valid_in    = 1'b0;
    reset       = 1'b0;
    rx_reset();
    @(negedge clk);

    // Sync burst then IDLE fill
    do_reset(2);
    run_idle(64);

    // Two back-to-back payload bytes at edges 33 and 41
    do_reset(2);
    run_idle(32);
    valid_in = 1'b1; data_in = 8'hA5;
    repeat (8) step();
    data_in = 8'h3C;
    repeat (8) step();
    run_idle(16);

    // One valid window, then a stray valid around edge 36 that must be ignored
    do_reset(2);
    run_idle(32);
    valid_in = 1'b1; data_in = 8'hFF;
    step();
    valid_in = 1'b0;
    step(); step();
    valid_in = 1'b1; data_in = 8'h55;
    step();
    run_idle(20);

    // Reset mid-payload: asserted between edges 36 and 37 while a 1 bit is on the line
    do_reset(2);
    run_idle(32);
    valid_in = 1'b1; data_in = 8'hFF;
    repeat (4) step();
    check("pre_reset_serial", {31'd0, serial_a}, 32'd1);
    do_reset(3);
    run_idle(40);

    // Random payload with random valid
    for (int i = 0; i < 2000; i++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      data_in  = 8'($urandom);
      step();
    end
    check("rx_bytes_seen", {31'd0, rx_bytes > 250}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_serializer.md
Name: tx_serializer

Overview:
- Transmit-side serializer that produces one lane's serial bit stream. The receive path's serial-to-parallel stage consumes this stream.
- After reset it emits a burst of COM (0xBC) alignment symbols. The receiver uses these to find byte boundaries.
- After the burst it sends upstream payload bytes MSB-first, or IDLE (0x7C) when upstream has no valid byte.
- Single bit-rate clock. Upstream bytes are pulled with a ready/valid strobe once every 8 cycles.

Parameters:
- COM, 8'hBC, alignment symbol sent during the sync burst.
- IDLE, 8'h7C, filler symbol sent when no valid byte is offered at a load edge.
- SYNC_COUNT, 4, number of COM symbols sent after reset (legal range 1..255).

Ports:
- clk  input  1  bit-rate clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- data_in  input  8  payload byte offered by upstream.
- valid_in  input  1  data_in holds a valid byte.
- ready_out  output  1  high for the one cycle whose closing edge is an ACTIVE-state load edge.
- data_serial_out  output  1  serial stream, MSB of each byte first, registered.
- active_out  output  1  high once the COM burst is complete (state ACTIVE).

Behaviour:
- Reset (reset=0, asynchronous) values:
  - shift register = 0, bit_cnt = 0, sync_cnt = 0, state = SYNC.
  - data_serial_out = 0, active_out = 0, ready_out = 0.
- bit_cnt is 3 bits, increments by 1 every edge and wraps 7→0.
- An edge where bit_cnt == 0 is a load edge:
  - load the selected byte into the shift register;
  - data_serial_out takes bit 7 of that byte.
- On edges where bit_cnt is 1..7, data_serial_out takes the next lower bit. The LSB of a byte is driven 7 edges after its load edge.
- State SYNC:
  - each load edge selects COM and increments sync_cnt;
  - on the load edge that loads the SYNC_COUNT-th COM, state becomes ACTIVE and sync_cnt holds.
- State ACTIVE:
  - each load edge selects data_in if valid_in = 1, else IDLE;
  - state stays ACTIVE until reset.
- ready_out = (state == ACTIVE) && (bit_cnt == 0). It is decoded from registers only and has no combinational path from valid_in.
  - A byte is consumed iff ready_out && valid_in at the edge.
  - Upstream must hold data_in stable through that edge.
  - valid_in while ready_out = 0 is ignored; no byte is consumed or queued.
- active_out = (state == ACTIVE); it rises on the same edge that loads the final COM.
- Default timing, first edge after reset release counted as edge 1:
  - COMs are loaded at edges 1, 9, 17, 25;
  - active_out rises at edge 25;
  - ready_out is first high between edges 32 and 33;
  - the first payload byte is loaded at edge 33.
- Latency: a byte accepted at edge E appears on data_serial_out from E (bit 7) through E+7 (bit 0).
- Back-to-back: valid_in held high with a new byte each ready window gives a gap-free stream, with no IDLE inserted.
- Reset asserted mid-byte: all state clears immediately and output goes 0. On release the COM burst restarts from sync_cnt = 0, and the partial byte is lost.
- No buffering: the block holds at most one byte, the one currently in the shift register.

Test Plan:
1. Release reset, valid_in = 0 for 64 cycles → stream is BC,BC,BC,BC, then 7C,7C,7C,7C. Bits are MSB-first, so the first 8 bits are 1,0,1,1,1,1,0,0. active_out rises at edge 25. ready_out pulses at cycles 32, 40, 48, 56.
2. After sync, offer 0xA5 then 0x3C with valid_in = 1 in consecutive ready windows → serial bits 10100101 00111100 with no gap. The transfers occur at edges 33 and 41.
3. After sync, valid_in = 1 for one window only, with data 0xFF, then 0 → stream FF,7C,7C. valid_in asserted while ready_out = 0 (e.g. at edge 36) has no effect.
4. SYNC_COUNT = 1 → a single BC, then ready_out first high in cycle 8. The first payload is loaded at edge 9.
5. Assert reset at edge 37, mid-payload-byte, for 3 cycles → data_serial_out, active_out and ready_out go 0 immediately. On release a full 4-COM burst restarts.
6. Random data, random valid_in over 2000 cycles, with a receiver model that aligns on BC → the recovered byte sequence equals the accepted bytes with IDLEs in place of idle windows. Zero bytes are dropped or duplicated.
